// File: rtl/cdc_ctrl_pkg.sv
// Shared types and constants for the source-side req/ack CDC handshake controller.
// The helper sizes the timeout counter so a zero timeout still leaves a legal 1-bit register.
package cdc_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RELEASE, ABORT} hs_state_e;

    localparam int unsigned CDC_SYNC_LAT = 2;

    function automatic int unsigned tcnt_width(input int unsigned cyc);
        return (cyc == 0) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/sync_2dff.sv
// Flop synchroniser for a single level signal, CDC_SYNC_LAT stages deep.
// With SYNTHESIS=0 an LFSR randomly adds one cycle per transition to mimic metastability jitter.
module sync_2dff
    import cdc_ctrl_pkg::*;
#(
    parameter int   SYNTHESIS = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [CDC_SYNC_LAT-1:0] stages;
    logic                    sync_out;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stages <= {CDC_SYNC_LAT{RESET_VAL}};
        end else begin
            stages <= {stages[CDC_SYNC_LAT-2:0], d_i};
        end
    end

    assign sync_out = stages[CDC_SYNC_LAT-1];

    generate
        if (SYNTHESIS != 0) begin : g_plain
            assign q_o = sync_out;
        end else begin : g_dynamic
            logic       late;
            logic       skip;
            logic [7:0] lfsr;

            // The extra-delay choice is frozen while a transition is in flight, so q_o stays monotonic.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    late <= RESET_VAL;
                    skip <= 1'b0;
                    lfsr <= 8'hA5;
                end else begin
                    late <= sync_out;
                    lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                    if (late == sync_out) begin
                        skip <= lfsr[0];
                    end
                end
            end

            assign q_o = skip ? sync_out : late;
        end
    endgenerate

endmodule

// File: rtl/cdc_hs_src_ctrl.sv
// Source-side controller for a 4-phase req/ack handshake: holds one accepted word on data_o,
// raises req_o, and waits for the resynchronised ack to rise and fall, with timeout and transfer count.
module cdc_hs_src_ctrl
    import cdc_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int          SYNTHESIS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              req_o,
    input  logic              ack_i,
    output logic              done_o,
    output logic              timeout_o,
    output logic              err_o,
    input  logic              err_clr_i,
    output logic [CNT_W-1:0]  xfer_cnt_o
);

    localparam int unsigned       TCNT_W    = tcnt_width(TIMEOUT_CYC);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

    hs_state_e         state;
    logic [TCNT_W-1:0] tcnt;
    logic              ack_s;
    logic              accept;
    logic              expired;
    logic              abort_now;
    logic              complete;

    // Synchroniser resets to "ack busy" so a stale ack after reset blocks new requests until it is seen low.
    sync_2dff #(
        .SYNTHESIS (SYNTHESIS),
        .RESET_VAL (1'b1)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rstn_i (~rst_i),
        .d_i    (ack_i),
        .q_o    (ack_s)
    );

    assign ready_o   = (state == IDLE) && !ack_s;
    assign accept    = valid_i && ready_o;
    assign expired   = (TIMEOUT_CYC != 0) && (tcnt == TCNT_LAST);
    assign abort_now = expired && (((state == REQ) && !ack_s) || ((state == RELEASE) && ack_s));
    assign complete  = (state == RELEASE) && !ack_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            req_o     <= 1'b0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            tcnt      <= '0;
        end else begin
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_o <= 1'b1;
                        tcnt  <= '0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        req_o <= 1'b0;
                        tcnt  <= '0;
                        state <= RELEASE;
                    end else if (abort_now) begin
                        req_o     <= 1'b0;
                        timeout_o <= 1'b1;
                        state     <= ABORT;
                    end else if (tcnt != TCNT_MAX) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end else if (abort_now) begin
                        timeout_o <= 1'b1;
                        state     <= ABORT;
                    end else if (tcnt != TCNT_MAX) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ABORT: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A timeout in the same cycle as err_clr_i leaves the error set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
            err_o  <= 1'b0;
        end else begin
            if (accept) begin
                data_o <= data_i;
            end
            if (abort_now) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xfer_cnt_o <= '0;
        end else if (complete) begin
            xfer_cnt_o <= xfer_cnt_o + 1'b1;
        end
    end

endmodule
